hazard_control: RTL and testbench
=================================

Name: hazard_control

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Takes the D-stage register addresses and Tuse/Tnew codes produced by the decode control unit.
- Tracks destination register and remaining Tnew for every in-flight instruction in internal E/M/W shadow registers.
- Drives the stall/bubble controls and the forwarding-mux selects for the D-stage comparator and E-stage ALU operands.

Parameters:
- ADDR_W, 5, register-address width.
- TUSE_NONE, 3, Tuse code meaning "operand not read"; never causes a stall.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rsD  in  ADDR_W  rs field of the instruction in D.
- rtD  in  ADDR_W  rt field of the instruction in D.
- rsTuseD  in  2  cycles from D until rs is consumed (0 = D, 1 = E, 2 = M, 3 = unused).
- rtTuseD  in  2  same, for rt.
- dstD  in  ADDR_W  destination register of the D instruction (after RegDst resolution).
- regWriteD  in  1  the D instruction writes the register file.
- tNewD  in  2  cycles from D until the result is produced (ALU 2, load 3, jal 0).
- stall  out  1  hold PC and the F/D register; bubble E.
- fwdRsD  out  2  D-comparator rs source: 0 GRF, 1 E-stage PC+8, 2 M-stage result.
- fwdRtD  out  2  same, for rt.
- fwdRsE  out  2  E-ALU rs source: 0 pipeline register, 1 M result, 2 W result.
- fwdRtE  out  2  same, for rt.

Behaviour:
- State: per stage S in {E, M, W}: dstS, tNewS (2b), and for E also rsE and rtE.
- dstS = 0 whenever the instruction does not write; $0 is never a hazard source.
- reset (asynchronous): all state registers go to 0. Outputs are combinational on state, so stall = 0 and all fwd* = 0 while reset is held. Reset mid-stall discards the pending stall.
- Each rising edge, no stall:
  - E <= D: dstE = regWriteD ? dstD : 0; tNewE = sat(tNewD - 1); rsE <= rsD; rtE <= rtD.
  - M <= E with tNewM = sat(tNewE - 1).
  - W <= M with tNewW = 0.
  - sat(x - 1) clamps at 0.
- Each rising edge, stall = 1:
  - E loads a bubble: dst 0, tNew 0, rs/rt 0.
  - M <= E and W <= M advance normally.
  - D inputs are held externally and re-presented the next cycle.
- Stall (combinational): for each src in {rs, rt} with src != 0 and Tuse != TUSE_NONE, stall is raised if either holds:
  - dstE == src && tNewE > Tuse
  - dstM == src && tNewM > Tuse
- W never stalls. The GRF is write-first, so D reads W data directly.
- D forwarding priority is E over M:
  - 1 if dstE == src && tNewE == 0.
  - Else 2 if dstM == src && tNewM == 0.
  - Else 0.
- E forwarding priority is M over W:
  - 1 if dstM == rsE/rtE && tNewM == 0.
  - Else 2 if dstW matches.
  - Else 0.
  - Forward values are computed regardless of stall.
- A match with tNew > 0 never forwards; it must be covered by stall.
- Back-to-back writers to the same register: the younger stage wins, per the priorities above.
- Latency: stall and fwd outputs are purely combinational from the current D inputs plus registered state, with zero added cycles.

Test Plan:
- Reset: assert reset mid-stream with dstE = 5, tNewE = 2. Required: stall = 0 and all fwd = 0 immediately (asynchronous), and they stay 0 after release with no D hazards.
- ALU to ALU: add $3 (tNewD 2), then sub $4,$3,$1 (rsTuse 1). Required: no stall; next cycle fwdRsE = 1 from M.
- Load-use: lw $5 (tNewD 3), then add $6,$5,$0 (rsTuse 1). Required: stall = 1 for exactly 1 cycle, E bubble loaded (dstE = 0), then fwdRsE = 2 from W.
- Branch after load: lw $2, then beq $2,$2 (Tuse 0). Required: stall held 2 cycles, then fwdRsD = fwdRtD = 0 (GRF bypass from W).
- jal then jr $31 (Tuse 0). Required: no stall; fwdRsD = 1 from E PC+8.
- $0 destination: ori $0 followed by an add reading $0. Required: stall = 0 and all fwd = 0.

Source files
------------

// File: rtl/hazard_control.sv
// Pipeline hazard controller for the 5-stage MIPS core: tracks in-flight destinations
// and Tnew in E/M/W shadow registers and derives stall plus forwarding-mux selects.
module hazard_control #(
    parameter int         ADDR_W    = 5,
    parameter logic [1:0] TUSE_NONE = 2'd3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rsD,
    input  logic [ADDR_W-1:0] rtD,
    input  logic [1:0]        rsTuseD,
    input  logic [1:0]        rtTuseD,
    input  logic [ADDR_W-1:0] dstD,
    input  logic              regWriteD,
    input  logic [1:0]        tNewD,
    output logic              stall,
    output logic [1:0]        fwdRsD,
    output logic [1:0]        fwdRtD,
    output logic [1:0]        fwdRsE,
    output logic [1:0]        fwdRtE
);

    // Shadow state: _p0 = E, _p1 = M, _p2 = W. Tnew in W is always 0, so it is not stored.
    logic [ADDR_W-1:0] dst_p0, dst_p1, dst_p2;
    logic [1:0]        tnew_p0, tnew_p1;
    logic [ADDR_W-1:0] rs_p0, rt_p0;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic src_stall(
        input logic [ADDR_W-1:0] src,
        input logic [1:0]        tuse,
        input logic [ADDR_W-1:0] dst_e,
        input logic [1:0]        tnew_e,
        input logic [ADDR_W-1:0] dst_m,
        input logic [1:0]        tnew_m
    );
        logic active;
        active = (src != '0) && (tuse != TUSE_NONE);
        return active && (((dst_e == src) && (tnew_e > tuse)) ||
                          ((dst_m == src) && (tnew_m > tuse)));
    endfunction

    // $0 never forwards, even though bubbles and non-writers carry dst = 0.
    function automatic logic [1:0] fwd_d_sel(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst_e,
        input logic [1:0]        tnew_e,
        input logic [ADDR_W-1:0] dst_m,
        input logic [1:0]        tnew_m
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if ((dst_e == src) && (tnew_e == 2'd0)) begin
                sel = 2'd1;
            end else if ((dst_m == src) && (tnew_m == 2'd0)) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst_m,
        input logic [1:0]        tnew_m,
        input logic [ADDR_W-1:0] dst_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if ((dst_m == src) && (tnew_m == 2'd0)) begin
                sel = 2'd1;
            end else if (dst_w == src) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        stall  = src_stall(rsD, rsTuseD, dst_p0, tnew_p0, dst_p1, tnew_p1) |
                 src_stall(rtD, rtTuseD, dst_p0, tnew_p0, dst_p1, tnew_p1);
        fwdRsD = fwd_d_sel(rsD, dst_p0, tnew_p0, dst_p1, tnew_p1);
        fwdRtD = fwd_d_sel(rtD, dst_p0, tnew_p0, dst_p1, tnew_p1);
        fwdRsE = fwd_e_sel(rs_p0, dst_p1, tnew_p1, dst_p2);
        fwdRtE = fwd_e_sel(rt_p0, dst_p1, tnew_p1, dst_p2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_p0  <= '0;
            tnew_p0 <= 2'd0;
            rs_p0   <= '0;
            rt_p0   <= '0;
            dst_p1  <= '0;
            tnew_p1 <= 2'd0;
            dst_p2  <= '0;
        end else begin
            // D -> E: a stall injects a bubble while D is held upstream
            if (stall) begin
                dst_p0  <= '0;
                tnew_p0 <= 2'd0;
                rs_p0   <= '0;
                rt_p0   <= '0;
            end else begin
                dst_p0  <= regWriteD ? dstD : '0;
                tnew_p0 <= sat_dec(tNewD);
                rs_p0   <= rsD;
                rt_p0   <= rtD;
            end
            // E -> M
            dst_p1  <= dst_p0;
            tnew_p1 <= sat_dec(tnew_p0);
            // M -> W
            dst_p2  <= dst_p1;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed vector table, asynchronous-reset sequence and
// randomized traffic checked against an in-flight instruction model.
module tb_hazard_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, dstD;
    logic [1:0] rsTuseD, rtTuseD, tNewD;
    logic       regWriteD;
    logic       stall;
    logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE;

    int passed = 0;
    int total  = 0;

    hazard_control #(.ADDR_W(5), .TUSE_NONE(2'd3)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsTuseD(rsTuseD), .rtTuseD(rtTuseD),
        .dstD(dstD), .regWriteD(regWriteD), .tNewD(tNewD),
        .stall(stall), .fwdRsD(fwdRsD), .fwdRtD(fwdRtD),
        .fwdRsE(fwdRsE), .fwdRtE(fwdRtE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, dst;
        logic [1:0] rs_tuse, rt_tuse, tnew;
        logic       wr;
        logic       st;
        logic [1:0] f_rs_d, f_rt_d, f_rs_e, f_rt_e;
    } vec_t;

    // In-flight instruction model: index 0 = E, 1 = M, 2 = W.
    // Each entry keeps its original Tnew from D; remaining Tnew is derived from its age.
    typedef struct { int dst; int tn; int rs; int rt; } ent_t;
    ent_t pipe[3];

    function automatic int rem(int idx);
        return (pipe[idx].tn > idx + 1) ? pipe[idx].tn - (idx + 1) : 0;
    endfunction

    function automatic int m_stall(int rs, int rt, int rs_tu, int rt_tu);
        int src[2];
        int tu[2];
        src[0] = rs; src[1] = rt; tu[0] = rs_tu; tu[1] = rt_tu;
        for (int s = 0; s < 2; s++)
            if (src[s] != 0 && tu[s] != 3)
                for (int i = 0; i < 2; i++)
                    if (pipe[i].dst == src[s] && rem(i) > tu[s]) return 1;
        return 0;
    endfunction

    function automatic int m_fwd_d(int src);
        if (src == 0) return 0;
        for (int i = 0; i < 2; i++)
            if (pipe[i].dst == src && rem(i) == 0) return i + 1;
        return 0;
    endfunction

    function automatic int m_fwd_e(int src);
        if (src == 0) return 0;
        for (int i = 1; i < 3; i++)
            if (pipe[i].dst == src && rem(i) == 0) return i;
        return 0;
    endfunction

    task automatic m_advance(input int st);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st != 0) pipe[0] = '{0, 0, 0, 0};
        else pipe[0] = '{(regWriteD ? int'(dstD) : 0), int'(tNewD), int'(rsD), int'(rtD)};
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    endtask

    function automatic vec_t mk(int rs, int rt, int rst, int rtt, int dst, int wr, int tn,
                                int st, int frd, int ftd, int fre, int fte);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rs_tuse = 2'(rst); v.rt_tuse = 2'(rtt);
        v.dst = 5'(dst); v.wr = 1'(wr); v.tnew = 2'(tn);
        v.st = 1'(st); v.f_rs_d = 2'(frd); v.f_rt_d = 2'(ftd);
        v.f_rs_e = 2'(fre); v.f_rt_e = 2'(fte);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input int rs, input int rt, input int rst, input int rtt,
                         input int dst, input int wr, input int tn);
        rsD = 5'(rs); rtD = 5'(rt); rsTuseD = 2'(rst); rtTuseD = 2'(rtt);
        dstD = 5'(dst); regWriteD = 1'(wr); tNewD = 2'(tn);
    endtask

    task automatic check_all(input string tag, input int st, input int frd, input int ftd,
                             input int fre, input int fte);
        check({tag, "_stall"},  int'(stall),  st);
        check({tag, "_fwdRsD"}, int'(fwdRsD), frd);
        check({tag, "_fwdRtD"}, int'(fwdRtD), ftd);
        check({tag, "_fwdRsE"}, int'(fwdRsE), fre);
        check({tag, "_fwdRtE"}, int'(fwdRtE), fte);
    endtask

    vec_t tbl[20];

    initial begin
        // {rs, rt, rsTuse, rtTuse, dst, wr, tNew} -> {stall, fwdRsD, fwdRtD, fwdRsE, fwdRtE}
        tbl[0]  = mk( 1, 2, 1, 1,  3, 1, 2,  0, 0, 0, 0, 0); // add $3,$1,$2
        tbl[1]  = mk( 3, 1, 1, 1,  4, 1, 2,  0, 0, 0, 0, 0); // sub $4,$3,$1
        tbl[2]  = mk( 0, 0, 3, 3,  0, 0, 0,  0, 0, 0, 1, 0); // nop: sub rs from M
        tbl[3]  = mk( 1, 0, 1, 3,  5, 1, 3,  0, 0, 0, 0, 0); // lw $5
        tbl[4]  = mk( 5, 0, 1, 1,  6, 1, 2,  1, 0, 0, 0, 0); // add $6,$5,$0 load-use
        tbl[5]  = mk( 5, 0, 1, 1,  6, 1, 2,  0, 0, 0, 0, 0); // re-presented
        tbl[6]  = mk( 0, 0, 3, 3,  0, 0, 0,  0, 0, 0, 2, 0); // add rs from W
        tbl[7]  = mk( 1, 0, 1, 3,  2, 1, 3,  0, 0, 0, 0, 0); // lw $2
        tbl[8]  = mk( 2, 2, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0); // beq $2,$2
        tbl[9]  = mk( 2, 2, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0);
        tbl[10] = mk( 2, 2, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0); // GRF bypass from W
        tbl[11] = mk( 0, 0, 3, 3, 31, 1, 0,  0, 0, 0, 0, 0); // jal
        tbl[12] = mk(31, 0, 0, 3,  0, 0, 0,  0, 1, 0, 0, 0); // jr $31 from E PC+8
        tbl[13] = mk( 1, 0, 1, 3,  0, 1, 2,  0, 0, 0, 1, 0); // ori $0; jr rs from M
        tbl[14] = mk( 0, 0, 1, 1,  7, 1, 2,  0, 0, 0, 0, 0); // add $7,$0,$0
        tbl[15] = mk( 0, 0, 3, 3,  0, 0, 0,  0, 0, 0, 0, 0); // $0 never forwarded
        tbl[16] = mk( 0, 0, 1, 1,  8, 1, 2,  0, 0, 0, 0, 0); // add $8
        tbl[17] = mk( 0, 0, 1, 1,  8, 1, 2,  0, 0, 0, 0, 0); // add $8 again
        tbl[18] = mk( 8, 8, 1, 1,  9, 1, 2,  0, 2, 2, 0, 0); // add $9,$8,$8
        tbl[19] = mk( 0, 0, 3, 3,  0, 0, 0,  0, 0, 0, 1, 1); // younger M wins over W

        reset = 1'b1;
        drive(0, 0, 3, 3, 0, 0, 0);
        @(posedge clk); #1;
        check_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].rs_tuse, tbl[i].rt_tuse,
                  tbl[i].dst, tbl[i].wr, tbl[i].tnew);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].f_rs_d, tbl[i].f_rt_d,
                      tbl[i].f_rs_e, tbl[i].f_rt_e);
            @(posedge clk); #1;
        end

        // Asynchronous reset while a load-use stall is pending
        drive(1, 0, 1, 3, 5, 1, 3);
        @(posedge clk); #1;
        drive(5, 0, 1, 1, 6, 1, 2);
        #2;
        check("arst_pre_stall", int'(stall), 1);
        reset = 1'b1;
        #1;
        check_all("arst_held", 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        check("arst_released_stall", int'(stall), 0);
        @(posedge clk); #1;
        drive(0, 0, 3, 3, 0, 0, 0);
        @(negedge clk);
        check_all("arst_after", 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Randomized traffic against the model
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_reset();
        begin
            int hold = 0;
            int est;
            for (int c = 0; c < 3000; c++) begin
                if (hold == 0)
                    drive($urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3));
                est = m_stall(rsD, rtD, rsTuseD, rtTuseD);
                @(negedge clk);
                check_all($sformatf("rnd%0d", c), est, m_fwd_d(rsD), m_fwd_d(rtD),
                          m_fwd_e(pipe[0].rs), m_fwd_e(pipe[0].rt));
                @(posedge clk);
                m_advance(est);
                hold = est;
                #1;
                if ($urandom_range(0, 299) == 0) begin
                    reset = 1'b1;
                    #1;
                    reset = 1'b0;
                    m_reset();
                    hold = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
